cpu_run_ctrl: RTL and testbench

- Run/step/halt sequencer for the single-cycle CPU core. It drives the core's global_en, taking commands from the debug host over a valid/ready command port.
- It watches the commit stream (commit, commit_pc, commit_halt) to stop on the halt instruction, on step-count exhaustion, on a host STOP command or on a PC breakpoint.
- It keeps enabled-cycle and retired-instruction counters for the debug host.

---
 rtl/cpu_run_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer driving the core's global_en from debug-host commands.
// Optional post-commit PC breakpoint is compiled in with `define RUN_CTRL_BKPT_EN.
module cpu_run_ctrl #(
    parameter int          STEP_W   = 16,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,          // active low, asynchronous
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [STEP_W-1:0] i_cmd_arg,
    input  logic [31:0]       i_bkpt_pc,
    input  logic              i_bkpt_en,
    input  logic              i_commit,
    input  logic [31:0]       i_commit_pc,
    input  logic              i_commit_halt,
    output logic              o_global_en,
    output logic              o_busy,
    output logic              o_halted,
    output logic [1:0]        o_stop_cause,
    output logic [31:0]       o_last_pc,
    output logic [CNT_W-1:0]  o_cyc_cnt,
    output logic [CNT_W-1:0]  o_inst_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALTED} state_t;

    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_CMD  = 2'b01;
    localparam logic [1:0] C_DONE = 2'b10;
    localparam logic [1:0] C_BKPT = 2'b11;

    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic                r_gen;
    logic                r_busy;
    logic                r_halted;
    logic [1:0]          r_cause;
    logic [31:0]         r_last_pc;
    logic [CNT_W-1:0]    r_cyc;
    logic [CNT_W-1:0]    r_inst;

    logic                w_active;
    logic                w_halt_ev;
    logic                w_bkpt_ev;
    logic                w_stop_cmd;
    logic                w_run_cmd;
    logic                w_step_cmd;
    logic [STEP_W-1:0]   w_step_arg;

    // Every command is accepted on the cycle it is offered.
    assign o_cmd_ready = 1'b1;

    assign w_active   = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_halt_ev  = w_active && i_commit && i_commit_halt;
    assign w_stop_cmd = i_cmd_valid && (i_cmd_op == OP_STOP);
    assign w_run_cmd  = i_cmd_valid && (i_cmd_op == OP_RUN);
    assign w_step_cmd = i_cmd_valid && (i_cmd_op == OP_STEP);
    assign w_step_arg = (i_cmd_arg == '0) ? STEP_W'(1) : i_cmd_arg;

`ifdef RUN_CTRL_BKPT_EN
    assign w_bkpt_ev = w_active && i_commit && i_bkpt_en && (i_commit_pc == i_bkpt_pc);
`else
    logic w_unused_bkpt;
    assign w_unused_bkpt = ^{i_bkpt_pc, i_bkpt_en};
    assign w_bkpt_ev     = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_step    <= '0;
            r_gen     <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_cause   <= C_NONE;
            r_last_pc <= RESET_PC;
            r_cyc     <= '0;
            r_inst    <= '0;
        end else begin
            if (r_gen)
                r_cyc <= r_cyc + 1'b1;
            if (i_commit) begin
                r_inst    <= r_inst + 1'b1;
                r_last_pc <= i_commit_pc;
            end

            // Stop sources in priority order: halt, breakpoint, STOP, step exhaustion.
            if (w_halt_ev) begin
                r_state  <= S_HALTED;
                r_halted <= 1'b1;
                r_cause  <= C_DONE;
                r_gen    <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_bkpt_ev) begin
                r_state <= S_IDLE;
                r_cause <= C_BKPT;
                r_gen   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_run_cmd) begin
                            r_state <= S_RUN;
                            r_cause <= C_NONE;
                            r_gen   <= 1'b1;
                            r_busy  <= 1'b1;
                        end else if (w_step_cmd) begin
                            r_state <= S_STEP;
                            r_step  <= w_step_arg;
                            r_cause <= C_NONE;
                            r_gen   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (w_stop_cmd) begin
                            r_state <= S_IDLE;
                            r_cause <= C_CMD;
                            r_gen   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_STEP: begin
                        if (w_stop_cmd) begin
                            r_state <= S_IDLE;
                            r_cause <= C_CMD;
                            r_gen   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            // global_en is always high in STEP, so count every cycle.
                            r_step <= r_step - 1'b1;
                            if (r_step == STEP_W'(1)) begin
                                r_state <= S_IDLE;
                                r_cause <= C_DONE;
                                r_gen   <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    S_HALTED: begin
                        if (w_stop_cmd) begin
                            r_state  <= S_IDLE;
                            r_halted <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_gen   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_global_en  = r_gen;
    assign o_busy       = r_busy;
    assign o_halted     = r_halted;
    assign o_stop_cause = r_cause;
    assign o_last_pc    = r_last_pc;
    assign o_cyc_cnt    = r_cyc;
    assign o_inst_cnt   = r_inst;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a behavioural model predicts every cycle's outputs,
// a separate monitor compares them against the DUT one time unit after each rising edge.
module tb_cpu_run_ctrl;
    localparam int STEP_W = 16;
    localparam int CNT_W  = 32;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;
    logic [31:0]       bkpt_pc;
    logic              bkpt_en;
    logic              commit;
    logic [31:0]       commit_pc;
    logic              commit_halt;
    logic              global_en;
    logic              busy;
    logic              halted;
    logic [1:0]        stop_cause;
    logic [31:0]       last_pc;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  inst_cnt;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.STEP_W(STEP_W), .CNT_W(CNT_W), .RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op), .i_cmd_arg(cmd_arg),
        .i_bkpt_pc(bkpt_pc), .i_bkpt_en(bkpt_en),
        .i_commit(commit), .i_commit_pc(commit_pc), .i_commit_halt(commit_halt),
        .o_global_en(global_en), .o_busy(busy), .o_halted(halted), .o_stop_cause(stop_cause),
        .o_last_pc(last_pc), .o_cyc_cnt(cyc_cnt), .o_inst_cnt(inst_cnt)
    );

    typedef struct packed {
        logic             ready;
        logic             gen;
        logic             busy;
        logic             halted;
        logic [1:0]       cause;
        logic [31:0]      pc;
        logic [CNT_W-1:0] cyc;
        logic [CNT_W-1:0] inst;
    } snap_t;

    snap_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: run mode, remaining enabled cycles for STEP, and the visible outputs.
    int               m_mode;
    int unsigned      m_left;
    bit               m_gen, m_halted;
    bit [1:0]         m_cause;
    bit [31:0]        m_pc;
    bit [CNT_W-1:0]   m_cyc, m_inst;

    // Tiny core: retires one instruction per enabled cycle, stops itself after its halt instruction.
    bit [31:0] core_pc;
    bit [31:0] halt_pc;
    bit        core_halted;
    bit        rnd_mode;

    function automatic snap_t model_snap();
        snap_t s;
        s.ready  = 1'b1;
        s.gen    = m_gen;
        s.busy   = (m_mode == M_RUN) || (m_mode == M_STEP);
        s.halted = m_halted;
        s.cause  = m_cause;
        s.pc     = m_pc;
        s.cyc    = m_cyc;
        s.inst   = m_inst;
        return s;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_left = 0; m_gen = 0; m_halted = 0;
        m_cause = 2'b00; m_pc = 32'h0; m_cyc = '0; m_inst = '0;
    endtask

    task automatic model_edge();
        bit running = (m_mode == M_RUN) || (m_mode == M_STEP);
        bit stop    = cmd_valid && (cmd_op == 2'b11);
        bit brk     = 1'b0;
`ifdef RUN_CTRL_BKPT_EN
        brk = running && commit && bkpt_en && (commit_pc == bkpt_pc);
`endif
        if (m_gen) m_cyc = m_cyc + 1;
        if (commit) begin
            m_inst = m_inst + 1;
            m_pc   = commit_pc;
        end
        if (running && commit && commit_halt) begin
            m_mode = M_HALT; m_halted = 1; m_cause = 2'b10;
        end else if (brk) begin
            m_mode = M_IDLE; m_cause = 2'b11;
        end else if (running && stop) begin
            m_mode = M_IDLE; m_cause = 2'b01;
        end else if (m_mode == M_HALT && stop) begin
            m_mode = M_IDLE; m_halted = 0;
        end else if (m_mode == M_STEP) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_mode = M_IDLE; m_cause = 2'b10;
            end
        end else if (m_mode == M_IDLE && cmd_valid && cmd_op == 2'b01) begin
            m_mode = M_RUN; m_cause = 2'b00;
        end else if (m_mode == M_IDLE && cmd_valid && cmd_op == 2'b10) begin
            m_mode = M_STEP; m_cause = 2'b00;
            m_left = (cmd_arg == 0) ? 1 : int'(cmd_arg);
        end
        m_gen = (m_mode == M_RUN) || (m_mode == M_STEP);
    endtask

    // Called just after a falling edge: drive this cycle's inputs, predict the next edge, wait.
    task automatic cyc(input bit v, input logic [1:0] op, input logic [STEP_W-1:0] arg);
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = arg;
        if (rnd_mode) begin
            commit      = m_gen ? 1'b1 : ($urandom_range(7) == 0);
            commit_pc   = 32'($urandom_range(3)) * 4;
            commit_halt = commit && ($urandom_range(39) == 0);
            bkpt_en     = $urandom_range(1) == 1;
        end else begin
            commit      = m_gen && !core_halted;
            commit_pc   = core_pc;
            commit_halt = commit && (core_pc == halt_pc);
            if (commit) begin
                core_pc = core_pc + 4;
                if (commit_halt) core_halted = 1;
            end
        end
        if (!rst_n) model_reset();
        else        model_edge();
        exp_q.push_back(model_snap());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, '0);
    endtask

    task automatic core_restart(input logic [31:0] hpc);
        core_pc = 32'h0; halt_pc = hpc; core_halted = 0;
    endtask

    // Monitor: one comparison per rising edge against the oldest prediction.
    initial begin
        snap_t e, a;
        forever begin
            @(posedge clk);
            #1;
            n_tests++;
            a = '{ready: cmd_ready, gen: global_en, busy: busy, halted: halted,
                  cause: stop_cause, pc: last_pc, cyc: cyc_cnt, inst: inst_cnt};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow t=%0t no prediction queued", $time);
            end else begin
                e = exp_q.pop_front();
                if (a !== e)
                    begin
                        n_fail++;
                        $display("FAIL cycle_state t=%0t got rdy=%0b en=%0b busy=%0b halt=%0b cause=%0d pc=%h cyc=%0d inst=%0d, want rdy=%0b en=%0b busy=%0b halt=%0b cause=%0d pc=%h cyc=%0d inst=%0d",
                                 $time, a.ready, a.gen, a.busy, a.halted, a.cause, a.pc, a.cyc, a.inst,
                                 e.ready, e.gen, e.busy, e.halted, e.cause, e.pc, e.cyc, e.inst);
                    end
            end
        end
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 0; cmd_op = 0; cmd_arg = 0;
        bkpt_pc = 32'h0000_0008; bkpt_en = 0;
        commit = 0; commit_pc = 0; commit_halt = 0;
        rnd_mode = 0;
        core_restart(32'hFFFF_FFFF);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // STEP 3, then STEP 0 (acts as 1)
        cyc(1'b1, 2'b10, 16'd3); idle(5);
        cyc(1'b1, 2'b10, 16'd0); idle(3);
        // cmd_arg changing after acceptance has no effect
        cyc(1'b1, 2'b10, 16'd2); cmd_arg = 16'd9; cyc(1'b0, 2'b10, 16'd9); idle(3);

        // RUN, STOP after 10 enabled cycles, RUN again resumes counting
        cyc(1'b1, 2'b01, '0); idle(9); cyc(1'b1, 2'b11, '0); idle(2);
        cyc(1'b1, 2'b01, '0); cyc(1'b1, 2'b10, 16'd1); idle(4); cyc(1'b1, 2'b11, '0); idle(2);

        // Halt instruction at PC 0x10; RUN/STEP ignored while halted; STOP releases
        core_restart(32'h0000_0010);
        cyc(1'b1, 2'b01, '0); idle(8);
        cyc(1'b1, 2'b01, '0); cyc(1'b1, 2'b10, 16'd4); idle(2);
        cyc(1'b1, 2'b11, '0); idle(2);

        // Breakpoint at 0x8 (stops only when compiled in), then resume without retrigger
        core_restart(32'hFFFF_FFFF);
        bkpt_en = 1;
        cyc(1'b1, 2'b01, '0); idle(6); cyc(1'b1, 2'b11, '0); idle(2);
        cyc(1'b1, 2'b01, '0); idle(4); cyc(1'b1, 2'b11, '0); idle(2);
        bkpt_en = 0;

        // Halt commit and STOP in the same cycle: halt wins
        core_restart(32'h0000_0008);
        cyc(1'b1, 2'b01, '0); idle(2); cyc(1'b1, 2'b11, '0); idle(2);
        cyc(1'b1, 2'b11, '0); idle(2);

        // Asynchronous reset mid-RUN: outputs must clear before the next edge
        core_restart(32'hFFFF_FFFF);
        cyc(1'b1, 2'b01, '0); idle(5);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (global_en !== 1'b0 || busy !== 1'b0 || cyc_cnt !== '0 || inst_cnt !== '0 ||
            last_pc !== 32'h0 || stop_cause !== 2'b00 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got en=%0b busy=%0b cyc=%0d inst=%0d pc=%h cause=%0d halt=%0b, want all zero",
                     global_en, busy, cyc_cnt, inst_cnt, last_pc, stop_cause, halted);
        end
        commit = 0;
        cyc(1'b0, 2'b00, '0);
        rst_n = 1'b1;
        idle(2);

        // Randomized traffic exercising priorities and trailing commits
        rnd_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            bit v = ($urandom_range(3) == 0);
            cyc(v, 2'($urandom_range(3)), 16'($urandom_range(5)));
        end
        rnd_mode = 0;
        commit = 0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
